// File: rtl/prf_write_arbiter.sv
// prf_write_arbiter: per-requester FIFOs feeding a limited number of PRF
// write ports through a rotating-priority scheduler. Write-port outputs are
// registered, so a push reaches the PRF no earlier than two cycles later.
//
// Handshake: req_ready_o[r] is high whenever queue r holds fewer than QDEPTH
// entries and depends only on registered state. A push happens at the clock
// edge where req_valid_i[r] and req_ready_o[r] are both high. A requester
// that sees valid without ready must hold its request unchanged.
module prf_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_WPORT = 2,
    parameter int INDEX     = 7,
    parameter int WIDTH     = 64,
    parameter int QDEPTH    = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*INDEX-1:0]   req_addr_i,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic [NUM_WPORT-1:0]       wr_en_o,
    output logic [NUM_WPORT*INDEX-1:0] wr_addr_o,
    output logic [NUM_WPORT*WIDTH-1:0] wr_data_o,
    output logic                       pending_o
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Queue storage and bookkeeping
    logic [INDEX-1:0] mem_addr_q [NUM_REQ][QDEPTH];
    logic [INDEX-1:0] mem_addr_d [NUM_REQ][QDEPTH];
    logic [WIDTH-1:0] mem_data_q [NUM_REQ][QDEPTH];
    logic [WIDTH-1:0] mem_data_d [NUM_REQ][QDEPTH];
    logic [PW-1:0]    head_q     [NUM_REQ];
    logic [PW-1:0]    head_d     [NUM_REQ];
    logic [PW-1:0]    tail_q     [NUM_REQ];
    logic [PW-1:0]    tail_d     [NUM_REQ];
    logic [CW-1:0]    count_q    [NUM_REQ];
    logic [CW-1:0]    count_d    [NUM_REQ];

    logic [RW-1:0]    rr_ptr_q, rr_ptr_d;
    logic             pending_q, pending_d;

    logic [NUM_WPORT-1:0]       wr_en_q, wr_en_d;
    logic [NUM_WPORT*INDEX-1:0] wr_addr_q, wr_addr_d;
    logic [NUM_WPORT*WIDTH-1:0] wr_data_q, wr_data_d;

    // Scheduler results
    logic [INDEX-1:0]     head_addr [NUM_REQ];
    logic [WIDTH-1:0]     head_data [NUM_REQ];
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   push;
    logic [NUM_WPORT-1:0] port_vld;
    logic [INDEX-1:0]     port_addr [NUM_WPORT];
    logic [WIDTH-1:0]     port_data [NUM_WPORT];
    logic [RW-1:0]        last_grant;

    // Queue heads and ready flags, from registered state only
    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            head_addr[r]   = mem_addr_q[r][head_q[r]];
            head_data[r]   = mem_data_q[r][head_q[r]];
            req_ready_o[r] = (count_q[r] < CW'(QDEPTH));
        end
    end

    // Rotating scan from rr_ptr: grant the first NUM_WPORT non-empty heads,
    // skipping any head whose tag is already on a port this cycle
    always_comb begin
        int   idx;
        int   nport;
        logic conflict;
        idx        = 0;
        nport      = 0;
        conflict   = 1'b0;
        grant      = '0;
        port_vld   = '0;
        last_grant = rr_ptr_q;
        for (int k = 0; k < NUM_WPORT; k++) begin
            port_addr[k] = '0;
            port_data[k] = '0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            conflict = 1'b0;
            for (int k = 0; k < NUM_WPORT; k++) begin
                if (k < nport && port_addr[k] == head_addr[idx]) conflict = 1'b1;
            end
            if (nport < NUM_WPORT && count_q[idx] != '0 && !conflict) begin
                grant[idx]       = 1'b1;
                port_vld[nport]  = 1'b1;
                port_addr[nport] = head_addr[idx];
                port_data[nport] = head_data[idx];
                last_grant       = RW'(idx);
                nport            = nport + 1;
            end
        end
    end

    // Queue next state: push at tail, pop granted heads, track occupancy
    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        push       = '0;
        pending_d  = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            push[r] = req_valid_i[r] && req_ready_o[r];
            if (push[r]) begin
                mem_addr_d[r][tail_q[r]] = req_addr_i[r*INDEX +: INDEX];
                mem_data_d[r][tail_q[r]] = req_data_i[r*WIDTH +: WIDTH];
                tail_d[r] = tail_q[r] + PW'(1);
            end
            if (grant[r]) head_d[r] = head_q[r] + PW'(1);
            count_d[r] = count_q[r] + CW'(push[r]) - CW'(grant[r]);
            if (count_d[r] != '0) pending_d = 1'b1;
        end
    end

    // Write-port next state and round-robin pointer advance
    always_comb begin
        wr_en_d   = port_vld;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rr_ptr_d  = rr_ptr_q;
        for (int k = 0; k < NUM_WPORT; k++) begin
            if (port_vld[k]) begin
                wr_addr_d[k*INDEX +: INDEX] = port_addr[k];
                wr_data_d[k*WIDTH +: WIDTH] = port_data[k];
            end
        end
        if (|grant) begin
            if (int'(last_grant) == NUM_REQ - 1) rr_ptr_d = '0;
            else                                 rr_ptr_d = last_grant + RW'(1);
        end
    end

    // State registers; reset empties every queue and silences the ports
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                for (int e = 0; e < QDEPTH; e++) begin
                    mem_addr_q[r][e] <= '0;
                    mem_data_q[r][e] <= '0;
                end
                head_q[r]  <= '0;
                tail_q[r]  <= '0;
                count_q[r] <= '0;
            end
            rr_ptr_q  <= '0;
            pending_q <= 1'b0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rr_ptr_q   <= rr_ptr_d;
            pending_q  <= pending_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign pending_o = pending_q;

endmodule

// File: tb/tb_prf_write_arbiter.sv
// Bench for prf_write_arbiter: queue-based reference model, per-cycle compare
// on the falling edge, directed scenarios with literal expectations, then
// randomized traffic with occasional asynchronous resets.
module tb_prf_write_arbiter;
    localparam int NR = 4;
    localparam int NW = 2;
    localparam int IX = 7;
    localparam int WD = 64;
    localparam int QD = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [NR-1:0]    req_valid;
    logic [NR*IX-1:0] req_addr;
    logic [NR*WD-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic [NW-1:0]    wr_en;
    logic [NW*IX-1:0] wr_addr;
    logic [NW*WD-1:0] wr_data;
    logic             pending;

    prf_write_arbiter #(
        .NUM_REQ(NR), .NUM_WPORT(NW), .INDEX(IX), .WIDTH(WD), .QDEPTH(QD)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_data_i(req_data),
        .req_ready_o(req_ready), .wr_en_o(wr_en), .wr_addr_o(wr_addr),
        .wr_data_o(wr_data), .pending_o(pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [IX-1:0] a;
        logic [WD-1:0] d;
    } ent_t;

    ent_t             mq [NR][$];
    int               m_rr;
    logic [NW-1:0]    exp_en;
    logic [NW*IX-1:0] exp_addr;
    logic [NW*WD-1:0] exp_data;
    logic             exp_pend;
    bit               acc [NR];

    always @(posedge clk or posedge reset) begin
        int ng;
        int r;
        int last;
        bit dup;
        bit gr [NR];
        logic [IX-1:0] gtag [$];
        if (reset) begin
            for (int i = 0; i < NR; i++) begin
                mq[i].delete();
                acc[i] = 1'b0;
            end
            m_rr = 0; exp_en = '0; exp_addr = '0; exp_data = '0; exp_pend = 1'b0;
        end else begin
            // acceptance is decided on pre-edge occupancy
            for (int i = 0; i < NR; i++) acc[i] = req_valid[i] && (mq[i].size() < QD);
            ng = 0; last = 0; gtag.delete(); exp_en = '0;
            for (int i = 0; i < NR; i++) gr[i] = 1'b0;
            for (int i = 0; i < NR; i++) begin
                r = (m_rr + i) % NR;
                if (ng < NW && mq[r].size() > 0) begin
                    dup = 1'b0;
                    foreach (gtag[j]) if (gtag[j] == mq[r][0].a) dup = 1'b1;
                    if (!dup) begin
                        gr[r] = 1'b1;
                        exp_en[ng] = 1'b1;
                        exp_addr[ng*IX +: IX] = mq[r][0].a;
                        exp_data[ng*WD +: WD] = mq[r][0].d;
                        gtag.push_back(mq[r][0].a);
                        ng++;
                        last = r;
                    end
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (gr[i]) void'(mq[i].pop_front());
                if (acc[i]) mq[i].push_back({req_addr[i*IX +: IX], req_data[i*WD +: WD]});
            end
            if (ng > 0) m_rr = (last + 1) % NR;
            exp_pend = 1'b0;
            for (int i = 0; i < NR; i++) if (mq[i].size() > 0) exp_pend = 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [NR-1:0] exp_rdy;
        if (chk_on) begin
            for (int i = 0; i < NR; i++) exp_rdy[i] = (mq[i].size() < QD);
            chk("cyc_wr_en", 256'(wr_en), 256'(exp_en));
            chk("cyc_wr_addr", 256'(wr_addr), 256'(exp_addr));
            chk("cyc_wr_data", 256'(wr_data), 256'(exp_data));
            chk("cyc_pending", 256'(pending), 256'(exp_pend));
            chk("cyc_ready", 256'(req_ready), 256'(exp_rdy));
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [IX-1:0] a, input logic [WD-1:0] d);
        req_valid[r] = 1'b1;
        req_addr[r*IX +: IX] = a;
        req_data[r*WD +: WD] = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    int density;
    int tag_max;

    initial begin
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        #1;
        reset = 1'b1;
        #1;
        chk_on = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        // post-reset idle
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_wr_en", 256'(wr_en), 256'(2'b00));
            chk("idle_ready", 256'(req_ready), 256'(4'hF));
            chk("idle_pending", 256'(pending), 256'(1'b0));
        end

        // single request from requester 2
        set_req(2, 7'h15, 64'hDEAD);
        tick();
        req_valid = '0;
        chk("single_pending_after_push", 256'(pending), 256'(1'b1));
        tick();
        chk("single_wr_en", 256'(wr_en), 256'(2'b01));
        chk("single_addr0", 256'(wr_addr[IX-1:0]), 256'(7'h15));
        chk("single_data0", 256'(wr_data[WD-1:0]), 256'(64'hDEAD));
        tick();
        chk("single_wr_en_after", 256'(wr_en), 256'(2'b00));

        // four simultaneous distinct tags with rr_ptr at 0
        do_reset();
        for (int r = 0; r < NR; r++) set_req(r, 7'(8'h10 + r), 64'(32'h1000 + r));
        tick();
        req_valid = '0;
        tick();
        chk("four_en_a", 256'(wr_en), 256'(2'b11));
        chk("four_addr_a", 256'(wr_addr), 256'({7'h11, 7'h10}));
        tick();
        chk("four_en_b", 256'(wr_en), 256'(2'b11));
        chk("four_addr_b", 256'(wr_addr), 256'({7'h13, 7'h12}));
        chk("four_data_b", 256'(wr_data), 256'({64'h1003, 64'h1002}));
        tick();
        chk("four_en_c", 256'(wr_en), 256'(2'b00));

        // tag conflict: requesters 0 and 1 both target 0x20
        do_reset();
        set_req(0, 7'h20, 64'hA0);
        set_req(1, 7'h20, 64'hB0);
        tick();
        req_valid = '0;
        tick();
        chk("conf_en_a", 256'(wr_en), 256'(2'b01));
        chk("conf_addr_a", 256'(wr_addr[IX-1:0]), 256'(7'h20));
        chk("conf_data_a", 256'(wr_data[WD-1:0]), 256'(64'hA0));
        tick();
        chk("conf_en_b", 256'(wr_en), 256'(2'b01));
        chk("conf_data_b", 256'(wr_data[WD-1:0]), 256'(64'hB0));
        tick();
        chk("conf_en_c", 256'(wr_en), 256'(2'b00));

        // reset mid-flight
        for (int r = 0; r < NR; r++) set_req(r, 7'(8'h40 + r), 64'(r));
        tick();
        for (int r = 0; r < NR; r++) set_req(r, 7'(8'h50 + r), 64'(r + 16));
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_wr_en", 256'(wr_en), 256'(2'b00));
        chk("midrst_pending", 256'(pending), 256'(1'b0));
        chk("midrst_ready", 256'(req_ready), 256'(4'hF));
        req_valid = '0;
        repeat (2) tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("midrst_quiet", 256'(wr_en), 256'(2'b00));
        end

        // randomized traffic; held requests stay unchanged until accepted
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) begin
                density = $urandom_range(20, 100);
                tag_max = ($urandom_range(0, 1) == 1) ? 7 : 127;
            end
            for (int r = 0; r < NR; r++) begin
                if (!req_valid[r] || acc[r]) begin
                    if ($urandom_range(1, 100) <= density)
                        set_req(r, 7'($urandom_range(0, tag_max)), {$urandom, $urandom});
                    else
                        req_valid[r] = 1'b0;
                end
            end
            if (c % 700 == 350) begin
                #2;
                reset = 1'b1;
                #1;
                chk("rand_rst_wr_en", 256'(wr_en), 256'(2'b00));
                tick();
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end
        req_valid = '0;
        repeat (10) tick();
        chk("drain_pending", 256'(pending), 256'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
